// File: rtl/hedios_host.sv
`timescale 1ns/1ps
// hedios_host: Hedios debug-protocol UART initiator. Takes one command at a
// time from local logic and serialises its 8N1 frame. For slot reads it then
// collects the four little-endian reply bytes and returns them as one word,
// or reports a timeout if the endpoint goes quiet.
module hedios_host #(
    parameter int CLK_RATE       = 100_000_000,
    parameter int BAUD_RATE      = 1_000_000,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_param,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        tx_line,
    input  logic        rx_line
);
    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] OP_VAR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SEND_CMD, S_SEND_PARAM, S_WAIT_RSP} state_t;
    typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_t;

    state_t            state_reg, state_next;
    rx_state_t         rx_state_reg, rx_state_next;

    // Latched command
    logic [1:0]        op_reg;
    logic [31:0]       param_reg;
    logic [7:0]        param_bytes [4];

    // Transmitter
    logic              tx_active_reg;
    logic [9:0]        tx_shift_reg;
    logic [CNT_W-1:0]  tx_clk_cnt_reg;
    logic [3:0]        tx_bit_cnt_reg;
    logic [1:0]        param_cnt_reg;
    logic [1:0]        next_param_idx;
    logic              more_bytes;
    logic              tx_bit_end;
    logic              tx_byte_end;
    logic              accept;

    // Receiver
    logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CNT_W-1:0]  rx_cnt_reg;
    logic [2:0]        rx_bit_reg;
    logic [7:0]        rx_shift_reg;
    logic [7:0]        rx_byte_reg;
    logic              rx_valid_reg;
    logic              rx_half, rx_full, rx_hunting;

    // Reply assembly and timeout
    logic [TO_W-1:0]   to_cnt_reg;
    logic [1:0]        rsp_cnt_reg;
    logic [23:0]       rsp_stage_reg;
    logic [31:0]       rsp_data_reg;
    logic              rsp_valid_reg;
    logic              rsp_last;
    logic              to_fire;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_param_bytes
            assign param_bytes[gi] = param_reg[8*gi +: 8];
        end
    endgenerate

    assign accept         = cmd_valid && cmd_ready;
    assign tx_bit_end     = tx_active_reg && (tx_clk_cnt_reg == BIT_LAST);
    assign tx_byte_end    = tx_bit_end && (tx_bit_cnt_reg == 4'd9);
    assign next_param_idx = (state_reg == S_SEND_CMD) ? 2'd0 : param_cnt_reg + 2'd1;
    assign more_bytes     = ((state_reg == S_SEND_CMD) && (op_reg == OP_VAR)) ||
                            ((state_reg == S_SEND_PARAM) && (param_cnt_reg != 2'd3));
    assign tx_line        = tx_active_reg ? tx_shift_reg[0] : 1'b1;

    assign rsp_last       = (state_reg == S_WAIT_RSP) && rx_valid_reg && (rsp_cnt_reg == 2'd3);
    assign to_fire        = (state_reg == S_WAIT_RSP) && (to_cnt_reg == TO_LIMIT);
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;

    // Command FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command FSM next-state: each frame byte ends on its stop bit's last cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_SEND_CMD;
            end
            S_SEND_CMD: begin
                if (tx_byte_end) begin
                    case (op_reg)
                        OP_VAR:  state_next = S_SEND_PARAM;
                        OP_READ: state_next = S_WAIT_RSP;
                        default: state_next = S_IDLE;
                    endcase
                end
            end
            S_SEND_PARAM: begin
                if (tx_byte_end && (param_cnt_reg == 2'd3)) state_next = S_IDLE;
            end
            S_WAIT_RSP: begin
                if (rsp_last || to_fire) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command FSM outputs
    always_comb begin
        cmd_ready   = (state_reg == S_IDLE);
        busy        = (state_reg != S_IDLE);
        rsp_timeout = to_fire;
    end

    // Transmitter: 10-bit shift frame; the next byte loads on the stop bit's last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg         <= '0;
            param_reg      <= '0;
            tx_active_reg  <= 1'b0;
            tx_shift_reg   <= '1;
            tx_clk_cnt_reg <= '0;
            tx_bit_cnt_reg <= '0;
            param_cnt_reg  <= '0;
        end else if (accept) begin
            op_reg         <= cmd_op;
            param_reg      <= cmd_param;
            tx_active_reg  <= 1'b1;
            tx_shift_reg   <= {1'b1, cmd_op, cmd_index, 1'b0};
            tx_clk_cnt_reg <= '0;
            tx_bit_cnt_reg <= '0;
            param_cnt_reg  <= '0;
        end else if (tx_bit_end) begin
            tx_clk_cnt_reg <= '0;
            if (tx_bit_cnt_reg == 4'd9) begin
                tx_bit_cnt_reg <= '0;
                if (more_bytes) begin
                    tx_shift_reg  <= {1'b1, param_bytes[next_param_idx], 1'b0};
                    param_cnt_reg <= next_param_idx;
                end else begin
                    tx_active_reg <= 1'b0;
                    tx_shift_reg  <= '1;
                end
            end else begin
                tx_shift_reg   <= {1'b1, tx_shift_reg[9:1]};
                tx_bit_cnt_reg <= tx_bit_cnt_reg + 4'd1;
            end
        end else if (tx_active_reg) begin
            tx_clk_cnt_reg <= tx_clk_cnt_reg + CNT_W'(1);
        end
    end

    assign rx_half    = (rx_cnt_reg == HALF_LAST);
    assign rx_full    = (rx_cnt_reg == BIT_LAST);
    assign rx_hunting = (rx_state_reg == R_HUNT);

    // Receiver state register plus rx_line synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= R_HUNT;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_meta_reg  <= rx_line;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
        end
    end

    // Receiver next-state: falling edge starts, mid-start re-check rejects glitches
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            R_HUNT:  if (rx_prev_reg && !rx_sync_reg) rx_state_next = R_START;
            R_START: if (rx_half) rx_state_next = rx_sync_reg ? R_HUNT : R_DATA;
            R_DATA:  if (rx_full && (rx_bit_reg == 3'd7)) rx_state_next = R_STOP;
            R_STOP:  if (rx_full) rx_state_next = R_HUNT;
            default: rx_state_next = R_HUNT;
        endcase
    end

    // Receiver datapath: bit-centre sampling, byte strobe only on a good stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_byte_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                R_HUNT: begin
                    rx_cnt_reg <= '0;
                end
                R_START: begin
                    if (rx_half) begin
                        rx_cnt_reg <= '0;
                        rx_bit_reg <= '0;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (rx_full) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (rx_full) begin
                        rx_cnt_reg <= '0;
                        if (rx_sync_reg) begin
                            rx_byte_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    end
                end
                default: rx_cnt_reg <= '0;
            endcase
        end
    end

    // Reply assembly and idle timeout; only bytes arriving in WAIT_RSP count
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg    <= '0;
            rsp_cnt_reg   <= '0;
            rsp_stage_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            if (state_reg != S_WAIT_RSP) begin
                to_cnt_reg  <= '0;
                rsp_cnt_reg <= '0;
            end else if (rx_valid_reg) begin
                to_cnt_reg <= '0;
                if (rsp_cnt_reg == 2'd3) begin
                    rsp_data_reg  <= {rx_byte_reg, rsp_stage_reg};
                    rsp_valid_reg <= 1'b1;
                end else begin
                    case (rsp_cnt_reg)
                        2'd0:    rsp_stage_reg[7:0]   <= rx_byte_reg;
                        2'd1:    rsp_stage_reg[15:8]  <= rx_byte_reg;
                        default: rsp_stage_reg[23:16] <= rx_byte_reg;
                    endcase
                    rsp_cnt_reg <= rsp_cnt_reg + 2'd1;
                end
            end else if (rx_hunting && (to_cnt_reg != TO_LIMIT)) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hedios_host.sv
`timescale 1ns/1ps
// Bench for hedios_host: frames on tx_line are decoded cycle by cycle against
// byte lists built from the command, and replies come from a UART driver.
module tb_hedios_host;
    localparam int CPB      = 100;
    localparam int TO       = 3000;
    localparam int BYTE_CYC = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_param = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic        tx_line;
    logic        rx_line = 1'b1;

    hedios_host #(
        .CLK_RATE(100_000_000),
        .BAUD_RATE(1_000_000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_index(cmd_index),
        .cmd_param(cmd_param),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .tx_line(tx_line),
        .rx_line(rx_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rsp = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Endpoint-side UART byte; ts returns the cycle the stop bit was driven
    task automatic drive_byte(input logic [7:0] b, input logic stop_bit, output int ts);
        @(negedge clk);
        rx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_line = stop_bit;
        ts = cyc;
        repeat (CPB) @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic do_accept(input logic [1:0] op, input logic [5:0] idx, input logic [31:0] p,
                             output int a);
        @(negedge clk);
        cmd_op    = op;
        cmd_index = idx;
        cmd_param = p;
        cmd_valid = 1'b1;
        check_eq("ready_idle", cmd_ready, 1);
        a = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_index = 6'($urandom);
        cmd_param = $urandom;
    endtask

    // Every cycle of every byte is compared with the ideal 8N1 waveform
    task automatic check_frame(input logic [7:0] bytes[$], input int inj_at);
        logic [9:0] fr;
        logic [7:0] got;
        int         bad, busy_bad, g;
        for (int bi = 0; bi < bytes.size(); bi++) begin
            fr = {1'b1, bytes[bi], 1'b0};
            got = '0;
            bad = 0;
            busy_bad = 0;
            for (int k = 0; k < BYTE_CYC; k++) begin
                @(negedge clk);
                g = bi * BYTE_CYC + k;
                if (inj_at >= 0 && g == inj_at) begin
                    cmd_op    = 2'b01;
                    cmd_index = 6'($urandom);
                    cmd_valid = 1'b1;
                end
                if (inj_at >= 0 && g == inj_at + 1) cmd_valid = 1'b0;
                if (tx_line !== fr[k / CPB]) bad++;
                if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8) got[k / CPB - 1] = tx_line;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) busy_bad++;
            end
            check_eq("tx_byte", got, bytes[bi]);
            check_eq("tx_bit_timing_errs", bad, 0);
            check_eq("busy_during_frame_errs", busy_bad, 0);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] idx, input logic [31:0] p,
                           input int nrep, input bit bad_first, input logic [31:0] rep_word,
                           input int inj_at);
        logic [7:0]  q[$];
        logic [31:0] vdata;
        int a, ts, vcount, tcount, both, tcyc, idle_seen, off;
        q.push_back({op, idx});
        if (op == 2'b10) for (int i = 0; i < 4; i++) q.push_back(p[8*i +: 8]);
        do_accept(op, idx, p, a);
        check_frame(q, inj_at);
        @(negedge clk);
        if (op != 2'b11) begin
            check_eq("ready_after_frame", cmd_ready, 1);
            $display("[%0d] cmd op=%0d idx=%0d param=%h bytes=%0d done", cyc, op, idx, p, q.size());
        end else begin
            check_eq("busy_in_wait", busy, 1);
            vcount = 0; tcount = 0; both = 0; tcyc = -1; ts = -1; idle_seen = 0; vdata = '0;
            fork
                begin
                    int dummy;
                    if (bad_first) begin
                        drive_byte(8'hA5, 1'b0, dummy);
                        repeat (200) @(negedge clk);
                    end else begin
                        repeat (30) @(negedge clk);
                    end
                    for (int i = 0; i < nrep; i++) begin
                        repeat ($urandom_range(20)) @(negedge clk);
                        drive_byte(rep_word[8*i +: 8], 1'b1, ts);
                    end
                end
                begin
                    for (int c = 0; c < TO + 8000 && idle_seen < 5; c++) begin
                        @(negedge clk);
                        if (rsp_valid) begin
                            vcount++;
                            vdata = rsp_data;
                        end
                        if (rsp_timeout) begin
                            tcount++;
                            tcyc = cyc;
                        end
                        if (rsp_valid && rsp_timeout) both++;
                        if (cmd_ready) idle_seen++;
                    end
                end
            join
            check_eq("wait_bound_idle_cycles", idle_seen, 5);
            check_eq("valid_and_timeout_together", both, 0);
            if (nrep == 4) begin
                check_eq("rsp_valid_pulses", vcount, 1);
                check_eq("rsp_timeout_pulses", tcount, 0);
                check_eq("rsp_word", vdata, rep_word);
                model_rsp = rep_word;
            end else begin
                check_eq("rsp_timeout_pulses", tcount, 1);
                check_eq("rsp_valid_pulses", vcount, 0);
                if (nrep == 0 && !bad_first) begin
                    check_eq("timeout_cycle", tcyc, a + BYTE_CYC + 1 + TO);
                end else begin
                    off = tcyc - ts - TO;
                    check_eq("timeout_after_last_byte_ok", (off >= 45 && off <= 65), 1);
                end
            end
            check_eq("rsp_data_held", rsp_data, model_rsp);
            $display("[%0d] read idx=%0d replies=%0d bad_first=%0d valid=%0d timeout=%0d data=%h",
                     cyc, idx, nrep, bad_first, vcount, tcount, rsp_data);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          a, ts, found, nrep;
        logic [1:0]  op;
        logic [7:0]  q[$];

        // Reset and idle
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("reset_tx_line", tx_line, 1);
        check_eq("reset_cmd_ready", cmd_ready, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_timeout", rsp_timeout, 0);
        check_eq("reset_rsp_data", rsp_data, 0);
        $display("[%0d] reset idle checked", cyc);

        // Varless action, 0x45
        run_cmd(2'b01, 6'd5, 32'h0, 0, 1'b0, 32'h0, -1);

        // Var action with a stray cmd_valid mid-frame
        run_cmd(2'b10, 6'd0, 32'hDEADBEEF, 0, 1'b0, 32'h0, 2500);

        // Stray reply byte while idle, then a good slot read
        drive_byte(8'h3C, 1'b1, ts);
        repeat (20) @(negedge clk);
        check_eq("stray_rsp_data", rsp_data, model_rsp);
        $display("[%0d] stray byte 3c sent while idle", cyc);
        run_cmd(2'b11, 6'd2, 32'h0, 4, 1'b0, 32'h12345678, -1);

        // Silent endpoint, then a reply that stops after two bytes
        run_cmd(2'b11, 6'd7, 32'h0, 0, 1'b0, 32'h0, -1);
        run_cmd(2'b11, 6'd9, 32'h0, 2, 1'b0, $urandom, -1);

        // Framing-error byte before a good reply
        run_cmd(2'b11, 6'd1, 32'h0, 4, 1'b1, $urandom, -1);

        // Reset while a var-action frame is driving a low bit
        do_accept(2'b10, 6'd3, $urandom, a);
        repeat (2300) @(negedge clk);
        found = 0;
        for (int c = 0; c < 1000 && found == 0; c++) begin
            @(negedge clk);
            if (tx_line == 1'b0) found = 1;
        end
        check_eq("low_bit_found", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midframe_rst_tx_line", tx_line, 1);
        check_eq("midframe_rst_cmd_ready", cmd_ready, 1);
        check_eq("midframe_rst_busy", busy, 0);
        check_eq("midframe_rst_rsp_data", rsp_data, 0);
        rst = 1'b0;
        model_rsp = '0;
        $display("[%0d] reset asserted mid-frame", cyc);

        // Randomised commands
        for (int t = 0; t < 5; t++) begin
            op = 2'($urandom);
            nrep = ($urandom_range(2) == 0) ? 2 : 4;
            run_cmd(op, 6'($urandom), $urandom, nrep, 1'b0, $urandom, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
